mem_arbiter: RTL and testbench

//  Shares one single-port memory between the instruction-fetch port (if_*) and
//  the load/store port (d_*) for the multicycle/pipelined core.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between the instruction-fetch
//               port (if_*) and the load/store port (d_*). Arbitrates
//               simultaneous requests, runs each access for WAIT_CYCLES+1
//               memory cycles and returns read data or a store ack to the
//               port that owned the access.
// Options     : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//               alternate between the two ports; otherwise data always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // shared memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic OWNER_F = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic              accept;
  logic              grant_d;
  logic              grant_f;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_owner;

  // Remember which port won the most recent grant so a conflict goes to the other one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWNER_F;
    end else if (grant_d) begin
      last_owner <= OWNER_D;
    end else if (grant_f) begin
      last_owner <= OWNER_F;
    end
  end
`endif

  // Arbitration: grants are only issued from IDLE/DONE, and never while reset is asserted
  always_comb begin
    accept = ((state == IDLE) || (state == DONE)) && !reset;
`ifdef ARB_ROUND_ROBIN_EN
    grant_d = accept && d_req && (!if_req || (last_owner == OWNER_F));
`else
    grant_d = accept && d_req;
`endif
    grant_f = accept && if_req && !grant_d;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (grant_d || grant_f) begin
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request, count wait states, capture read data on the last cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      owner     <= OWNER_F;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_d || grant_f) begin
        cnt       <= CNT_LOAD;
        owner     <= grant_d ? OWNER_D : OWNER_F;
        lat_addr  <= grant_d ? d_addr : if_addr;
        lat_we    <= grant_d && d_we;
        lat_wdata <= grant_d ? d_wdata : '0;
      end else if (state == ACCESS) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else if (owner == OWNER_F) begin
          if_rdata <= mem_rdata;
        end else if (!lat_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  // Memory side is driven only from latched state so requester changes never leak through
  always_comb begin
    if_gnt    = grant_f;
    d_gnt     = grant_d;
    if_rvalid = (state == DONE) && (owner == OWNER_F);
    d_rvalid  = (state == DONE) && (owner == OWNER_D);
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) && lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Drivers push the expected
//               response of each granted access; a monitor pops and compares
//               whenever the arbiter presents if_rvalid or d_rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int W = 1;

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic [31:0] ram [logic [31:0]];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory model: writes land during ACCESS, read data is presented by the last ACCESS cycle
  initial begin
    mem_rdata = 32'h0;
    ram[32'h10] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
      mem_rdata = mem_en ? rd(mem_addr) : 32'h0;
    end
  end

  // monitor: every rvalid must match the head of the scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (if_rvalid || d_rvalid) begin
      check("rvalid_exclusive", 64'(if_rvalid && d_rvalid), 64'd0);
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rv_port", 64'(d_rvalid), 64'(e.port));
        check("rv_data", 64'(e.port ? d_rdata : if_rdata), 64'(e.data));
        check("rv_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input bit push,
                       output int t_gnt, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    @(negedge clk);
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 0; n < 20; n++) begin
      #1;
      if ((port && d_gnt) || (!port && if_gnt)) begin
        got = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    check("gnt_seen", 64'(got), 64'd1);
    t_gnt = cyc;
    if (got && push) sb.push_back('{port, exp, cyc + 2 + W});
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '1; d_addr = '1; d_wdata = '1;
  endtask

  initial begin
    int   t;
    int   wt;
    int   ifg;
    int   tg[3];
    bit   got;
    bit   exp_seq[3];
    logic [31:0] t4_addr[3];
    logic [31:0] t4_data[3];

`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1;
`else
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1;
`endif
    t4_addr[0] = 32'h10; t4_data[0] = 32'hDEAD_BEEF;
    t4_addr[1] = 32'h20; t4_data[1] = 32'hC0DE_0020;
    t4_addr[2] = 32'h30; t4_data[2] = 32'hC0DE_0030;

    // reset with both requests raised: everything must stay at 0
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1;
    @(negedge clk); #1;
    check("rst_if_gnt", 64'(if_gnt), 64'd0);
    check("rst_d_gnt", 64'(d_gnt), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    check("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: fetch 0x10
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, t, wt);
    #1;
    check("t1_mem_en_a", 64'(mem_en), 64'd1);
    check("t1_mem_addr", 64'(mem_addr), 64'h10);
    check("t1_mem_we", 64'(mem_we), 64'd0);
    @(negedge clk); #1;
    check("t1_mem_en_b", 64'(mem_en), 64'd1);
    check("t1_mem_addr_b", 64'(mem_addr), 64'h10);
    @(negedge clk); #1;
    check("t1_mem_en_off", 64'(mem_en), 64'd0);
    repeat (3) @(negedge clk);

    // 2: store 0x12345678 to 0x40; d_rdata keeps its reset value
    issue(1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'h0, 1'b1, t, wt);
    #1;
    check("t2_mem_we", 64'(mem_we), 64'd1);
    check("t2_mem_addr", 64'(mem_addr), 64'h40);
    check("t2_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
    @(negedge clk); #1;
    check("t2_mem_we_b", 64'(mem_we && mem_en), 64'd1);
    repeat (4) @(negedge clk);

    // 3: both ports held for three grants
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (if_gnt || d_gnt) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("t3_gnt_seen", 64'(got), 64'd1);
      check("t3_single_gnt", 64'(if_gnt && d_gnt), 64'd0);
      check("t3_winner", 64'(d_gnt), 64'(exp_seq[k]));
      if (got) sb.push_back('{d_gnt, d_gnt ? 32'h1234_5678 : 32'hC0DE_0020, cyc + 2 + W});
      @(negedge clk);
      if (k == 2) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    repeat (4) @(negedge clk);

    // 4: back-to-back loads with d_req held
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = t4_addr[0];
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (d_gnt) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("t4_gnt_seen", 64'(got), 64'd1);
      tg[k] = cyc;
      if (got) sb.push_back('{1'b1, t4_data[k], cyc + 2 + W});
      @(negedge clk);
      if (k < 2) d_addr = t4_addr[k + 1];
      else d_req = 1'b0;
    end
    check("t4_gap_a", 64'(tg[1] - tg[0]), 64'(W + 2));
    check("t4_gap_b", 64'(tg[2] - tg[1]), 64'(W + 2));
    repeat (4) @(negedge clk);

    // 6: fetch raised then withdrawn while a store owns memory
    issue(1'b1, 1'b1, 32'h60, 32'hA5A5_A5A5, 32'hC0DE_0030, 1'b1, t, wt);
    if_req = 1'b1; if_addr = 32'h70;
    ifg = 0;
    #1; ifg += int'(if_gnt);
    @(negedge clk); #1; ifg += int'(if_gnt);
    if_req = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1; ifg += int'(if_gnt);
    end
    check("t6_no_if_gnt", 64'(ifg), 64'd0);
    repeat (2) @(negedge clk);

    // 5: reset in the second ACCESS cycle of a fetch
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, t, wt);
    @(negedge clk);
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    #1;
    check("t5_mem_en", 64'(mem_en), 64'd0);
    check("t5_mem_addr", 64'(mem_addr), 64'd0);
    check("t5_if_rdata", 64'(if_rdata), 64'd0);
    check("t5_d_rdata", 64'(d_rdata), 64'd0);
    check("t5_if_gnt", 64'(if_gnt), 64'd0);
    @(negedge clk);
    if_req = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, t, wt);
    check("t5_gnt_wait", 64'(wt), 64'd0);
    repeat (8) @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
